of_input_arbiter: RTL and testbench
===================================

# of_input_arbiter

Packet-granular round-robin arbiter that merges the NetFPGA-10G ingress AXI4-Stream ports into the single stream consumed by the OpenFlow datapath lookup pipeline. It sits between the per-port ingress queues and `openflow_datapath`. It grants one requester for a whole packet, never interleaving beats of different packets. A 2-entry output buffer decouples `m_axis_tready` from the ingress `tready` lines.

## Interface
- `C_AXIS_DATA_WIDTH`, 64: tdata width; tstrb width is `C_AXIS_DATA_WIDTH/8`.
- `C_AXIS_TUSER_WIDTH`, 128: tuser width; tuser is carried unmodified.
- `C_NUM_PORTS`, 5: number of requesters; legal range 2–8.
- `aclk`, in, 1: single clock.
- `aresetn`, in, 1: reset, asynchronous assert, active-low.
- `s_axis_tdata`, in, `C_NUM_PORTS*C_AXIS_DATA_WIDTH`: port i data is slice `[i*W +: W]`; the same slicing applies to every `s_axis_*` vector.
- `s_axis_tstrb`, in, `C_NUM_PORTS*C_AXIS_DATA_WIDTH/8`: byte strobes.
- `s_axis_tuser`, in, `C_NUM_PORTS*C_AXIS_TUSER_WIDTH`: sideband (len/spt/dpt).
- `s_axis_tvalid`, in, `C_NUM_PORTS`: per-port valid.
- `s_axis_tready`, out, `C_NUM_PORTS`: per-port ready; at most one bit is high.
- `s_axis_tlast`, in, `C_NUM_PORTS`: per-port end of packet.
- `m_axis_tdata`, `m_axis_tstrb`, `m_axis_tuser`, out, `C_AXIS_DATA_WIDTH`, `C_AXIS_DATA_WIDTH/8`, `C_AXIS_TUSER_WIDTH`: merged stream.
- `m_axis_tvalid`, out, 1; `m_axis_tready`, in, 1; `m_axis_tlast`, out, 1.
- `grant_port`, out, 3: index of the port currently or last granted.
- `busy`, out, 1: high in LOCKED state.

## Operation
- FSM has two states:
  - IDLE: round-robin search over the ports, starting at `grant_port+1` mod `C_NUM_PORTS`. The first port with `s_axis_tvalid` high wins. At the edge, `grant_port` ← winner and state → LOCKED. If no port has tvalid high, the block stays in IDLE.
  - LOCKED: `s_axis_tready[grant_port]` = (occupancy < 2); all other tready bits are 0. A beat is accepted when both valid and ready are high on the granted port. When the accepted beat has tlast = 1, state → IDLE at the same edge.
- Priority pointer: updated only on a grant. The port granted last always has the lowest priority in the next arbitration. The index wraps from `C_NUM_PORTS-1` to 0.
- Output buffer: 2-entry FIFO of {tdata, tstrb, tuser, tlast}.
  - Occupancy is 0..2.
  - `m_axis_tvalid` = (occupancy ≠ 0); the m_axis outputs come from the head entry.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - A push at occupancy 2 is impossible, because tready is low.
- No modification of payload or tuser. The block does no packet-length checking.
- Reset values (asynchronous, `aresetn` low):
  - state = IDLE, occupancy = 0.
  - `grant_port` = `C_NUM_PORTS-1`, so port 0 has first priority.
  - `m_axis_tvalid`/`tlast`/`tdata`/`tstrb`/`tuser` = 0, `s_axis_tready` = 0, `busy` = 0.
- Reset during a packet: the partial packet is discarded, including any beats held in the buffer. No tlast is emitted for it; this truncation is accepted behaviour.

## Timing
- Grant latency: `s_axis_tvalid` seen in IDLE at cycle n → tready high in cycle n+1.
- Pass-through latency: a beat accepted at edge k is presented on `m_axis` during the cycle after edge k. This is 1 cycle of latency.
- Throughput: with `m_axis_tready` held high, LOCKED sustains 1 beat/cycle.
- Packet overhead: exactly one IDLE cycle on the ingress side between consecutive packets.
- `s_axis_tready` is a decode of registered state and occupancy only. It has no combinational path from `m_axis_tready`.
- AXI-S rules:
  - `m_axis_tvalid` never drops before its handshake.
  - m_axis data stays stable while `tvalid && !tready`.
  - Ingress tvalid is not required to be held. An IDLE port that drops tvalid before it is granted simply loses its turn.

## Test plan
- Single 3-beat packet on port 2, with `tvalid` rising in cycle 0 and `m_axis_tready` = 1 → `s_axis_tready[2]` high from cycle 1. The `m_axis` beats appear in cycles 2, 3, 4 with tlast only in cycle 4, and `grant_port` = 2.
- All 5 ports continuously offering 1-beat packets after reset → grant order 0, 1, 2, 3, 4, 0, 1, …, with one output beat every 2 cycles.
- Ports 1 and 3 continuously requesting, with the last grant at 3 → next grant 1, then 3, alternating. Port 3 is never granted twice in a row.
- 8-beat packet on port 0 with `m_axis_tready` low for 4 cycles mid-packet → occupancy reaches 2 and `s_axis_tready[0]` = 0. All 8 beats arrive in order with no loss or duplication, and `m_axis_tdata` is stable while stalled.
- Packet from port 4 is 3 beats in flight when `aresetn` is pulsed low for 1 cycle → all outputs read 0 immediately. After release, a new request from port 4 together with one from port 0 → port 0 is granted first.
- 8-beat packet with `m_axis_tready` = 1 → 8 consecutive `m_axis_tvalid` cycles, no bubbles.

Source files
------------

// File: rtl/of_input_arbiter.sv
// -----------------------------------------------------------------------------
// of_input_arbiter
//
// Packet-granular round-robin arbiter. It merges C_NUM_PORTS ingress
// AXI4-Stream ports into the single stream that feeds the OpenFlow datapath
// lookup pipeline.
//
// Behaviour:
//   - One requester is granted for a whole packet. Beats of different packets
//     are never interleaved.
//   - A 2-entry output buffer decouples m_axis_tready from the ingress tready
//     lines.
//
// Ports:
//   aclk, aresetn      clock; asynchronous active-low reset
//   s_axis_tdata/...   C_NUM_PORTS ingress streams, port i is slice [i*W +: W]
//   s_axis_tready      per-port ready, at most one bit high (granted port only)
//   m_axis_*           merged egress stream (head entry of the output buffer)
//   grant_port         index of the port currently or last granted
//   busy               high while a packet is locked (FSM state observation)
//
// Handshake semantics:
//   - A beat moves on a channel at a rising edge where valid && ready.
//   - Producers hold m_axis data stable while valid && !ready.
//   - s_axis_tready is decoded from registered state and occupancy only.
//
// Legal C_NUM_PORTS range is 2..8, so grant_port always fits in 3 bits.
// -----------------------------------------------------------------------------
module of_input_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS        = 5
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                       s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]                       s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]                       s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]               m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         m_axis_tlast,
    output logic [2:0]                                   grant_port,
    output logic                                         busy
);

    localparam int W  = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int EW = W + SW + UW + 1;   // {tlast, tuser, tstrb, tdata}

    localparam logic [C_NUM_PORTS-1:0] PORT0 = {{(C_NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     grant_q, grant_d;

    // Output buffer: two entries addressed by 1-bit read/write pointers.
    logic [EW-1:0]  buf_q [2];
    logic           rd_ptr_q, wr_ptr_q;
    logic [1:0]     count_q, count_d;

    logic [W-1:0]   sel_data;
    logic [SW-1:0]  sel_strb;
    logic [UW-1:0]  sel_user;
    logic           sel_valid, sel_last;
    logic           in_ready, push, pop;

    // Ingress mux. The shifts select the slice of the granted port.
    assign sel_data  = W'(s_axis_tdata >> (32'(grant_q) * W));
    assign sel_strb  = SW'(s_axis_tstrb >> (32'(grant_q) * SW));
    assign sel_user  = UW'(s_axis_tuser >> (32'(grant_q) * UW));
    assign sel_valid = |(s_axis_tvalid & (PORT0 << grant_q));
    assign sel_last  = |(s_axis_tlast & (PORT0 << grant_q));

    // Ready depends only on registered state and occupancy. It never depends
    // on m_axis_tready, so there is no combinational path through the block.
    assign in_ready      = (state_q == ST_LOCKED) && (count_q != 2'd2);
    assign s_axis_tready = in_ready ? (PORT0 << grant_q) : '0;

    assign push = in_ready && sel_valid;
    assign pop  = (count_q != 2'd0) && m_axis_tready;

    // Next-state logic. In IDLE the search starts one past the last grant, so
    // the previously granted port has the lowest priority.
    always_comb begin
        int  cand;
        logic found;
        state_d = state_q;
        grant_d = grant_q;
        cand    = 0;
        found   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                for (int k = 1; k <= C_NUM_PORTS; k++) begin
                    cand = int'(grant_q) + k;
                    if (cand >= C_NUM_PORTS) begin
                        cand = cand - C_NUM_PORTS;
                    end
                    if (!found && (|(s_axis_tvalid & (PORT0 << cand)))) begin
                        found   = 1'b1;
                        grant_d = 3'(cand);
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (push && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= 3'(C_NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Reset also clears buffered beats, so a packet cut by reset is dropped
    // and the egress outputs read zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= {sel_last, sel_user, sel_strb, sel_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = buf_q[rd_ptr_q];
    assign m_axis_tvalid = (count_q != 2'd0);
    assign grant_port    = grant_q;
    assign busy          = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_of_input_arbiter.sv
module tb_of_input_arbiter;

    localparam int NP = 5;
    localparam int W  = 64;
    localparam int SW = 8;
    localparam int UW = 128;
    localparam int EW = W + SW + UW + 1;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [NP*W-1:0]  s_axis_tdata = '0;
    logic [NP*SW-1:0] s_axis_tstrb = '0;
    logic [NP*UW-1:0] s_axis_tuser = '0;
    logic [NP-1:0]    s_axis_tvalid = '0;
    logic [NP-1:0]    s_axis_tready;
    logic [NP-1:0]    s_axis_tlast = '0;
    logic [W-1:0]     m_axis_tdata;
    logic [SW-1:0]    m_axis_tstrb;
    logic [UW-1:0]    m_axis_tuser;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             m_axis_tlast;
    logic [2:0]       grant_port;
    logic             busy;

    of_input_arbiter #(
        .C_AXIS_DATA_WIDTH(W),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_NUM_PORTS(NP)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tstrb(s_axis_tstrb),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .grant_port(grant_port),
        .busy(busy)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [2:0]    got_grants[$];
    int            out_cycs[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    int  rem[NP];
    int  auto_len[NP];
    int  cyc;
    int  tready_rise_cyc, first_out_cyc, last_out_cyc, out_count;
    bit  saw_full;
    int  stall_at, stall_len;
    bit  prev_busy, prev_stall;
    logic [EW-1:0] held;

    typedef struct {
        int port;
        int len;
        int stall_at;
        int stall_len;
        bit exp_full;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic new_beat(input int p);
        s_axis_tdata[p*W +: W]   = {$urandom(), $urandom()};
        s_axis_tstrb[p*SW +: SW] = 8'($urandom_range(1, 255));
        s_axis_tuser[p*UW +: UW] = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_axis_tlast[p]          = (rem[p] == 1);
    endtask

    task automatic start_pkt(input int p, input int len);
        rem[p] = len;
        new_beat(p);
        s_axis_tvalid[p] = 1'b1;
    endtask

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            rem[p] = 0;
            auto_len[p] = 0;
        end
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
    endtask

    task automatic clear_stats();
        cyc = 0;
        tready_rise_cyc = -1;
        first_out_cyc = -1;
        last_out_cyc = -1;
        out_count = 0;
        saw_full = 1'b0;
        got_grants.delete();
        out_cycs.delete();
    endtask

    // One clock cycle: sample at the falling edge, update sources after the
    // rising edge.
    task automatic tick();
        logic [NP-1:0] hs;
        logic [EW-1:0] got;
        @(negedge aclk);
        hs  = s_axis_tvalid & s_axis_tready;
        got = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
        check("tready_onehot", 256'($countones(s_axis_tready) <= 1), 256'(1));
        if (prev_stall) begin
            check("stall_hold", {m_axis_tvalid, got}, {1'b1, held});
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        held = got;
        if (m_axis_tvalid && m_axis_tready) begin
            out_count++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            out_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h expected none", got);
            end else begin
                check("beat", got, exp_q.pop_front());
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                exp_q.push_back({s_axis_tlast[p], s_axis_tuser[p*UW +: UW],
                                 s_axis_tstrb[p*SW +: SW], s_axis_tdata[p*W +: W]});
            end
        end
        if (s_axis_tready != '0 && tready_rise_cyc < 0) tready_rise_cyc = cyc;
        if (busy && s_axis_tready == '0) saw_full = 1'b1;
        if (busy && !prev_busy) got_grants.push_back(grant_port);
        prev_busy = busy;
        @(posedge aclk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                rem[p]--;
                if (rem[p] == 0 && auto_len[p] > 0) rem[p] = auto_len[p];
                if (rem[p] > 0) begin
                    new_beat(p);
                end else begin
                    s_axis_tvalid[p] = 1'b0;
                    s_axis_tlast[p]  = 1'b0;
                end
            end
        end
        m_axis_tready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
    endtask

    task automatic drain(input int limit);
        int n;
        bit pending;
        n = 0;
        forever begin
            pending = 1'b0;
            for (int p = 0; p < NP; p++) if (rem[p] != 0) pending = 1'b1;
            if (!pending && exp_q.size() == 0 && !m_axis_tvalid && !busy) break;
            if (n >= limit) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        clear_sources();
        exp_q.delete();
        prev_busy = 1'b0;
        prev_stall = 1'b0;
        stall_len = 0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        check("rst_m_payload", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}, 256'(0));
        check("rst_s_tready", 256'(s_axis_tready), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_grant", 256'(grant_port), 256'(NP - 1));
        aresetn = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{port: 2, len: 3, stall_at: 0, stall_len: 0, exp_full: 1'b0};
        vecs[1] = '{port: 0, len: 8, stall_at: 4, stall_len: 4, exp_full: 1'b1};
        vecs[2] = '{port: 4, len: 8, stall_at: 0, stall_len: 0, exp_full: 1'b0};
        vecs[3] = '{port: 1, len: 1, stall_at: 0, stall_len: 0, exp_full: 1'b0};
        vecs[4] = '{port: 3, len: 5, stall_at: 3, stall_len: 2, exp_full: 1'b1};

        apply_reset();

        // Single packets, one per vector, starting from IDLE.
        for (int i = 0; i < 5; i++) begin
            clear_stats();
            stall_at  = vecs[i].stall_at;
            stall_len = vecs[i].stall_len;
            m_axis_tready = 1'b1;
            start_pkt(vecs[i].port, vecs[i].len);
            drain(200);
            check($sformatf("v%0d_grant", i), 256'(grant_port), 256'(vecs[i].port));
            check($sformatf("v%0d_tready_cyc", i), 256'(tready_rise_cyc), 256'(1));
            check($sformatf("v%0d_first_out", i), 256'(first_out_cyc), 256'(2));
            check($sformatf("v%0d_beats", i), 256'(out_count), 256'(vecs[i].len));
            check($sformatf("v%0d_full", i), 256'(saw_full), 256'(vecs[i].exp_full));
            if (vecs[i].stall_len == 0) begin
                check($sformatf("v%0d_last_out", i), 256'(last_out_cyc), 256'(vecs[i].len + 1));
            end
            stall_len = 0;
        end

        // All ports offering 1-beat packets from reset: strict rotation.
        apply_reset();
        clear_stats();
        for (int p = 0; p < NP; p++) begin
            auto_len[p] = 1;
            start_pkt(p, 1);
        end
        repeat (24) tick();
        for (int p = 0; p < NP; p++) auto_len[p] = 0;
        drain(100);
        check("rr_all_count", 256'(got_grants.size() >= 10), 256'(1));
        for (int i = 0; i < 10 && i < got_grants.size(); i++) begin
            check($sformatf("rr_all_g%0d", i), 256'(got_grants[i]), 256'(i % NP));
        end
        for (int i = 0; i < 9 && i + 1 < out_cycs.size(); i++) begin
            check($sformatf("rr_all_gap%0d", i), 256'(out_cycs[i+1] - out_cycs[i]), 256'(2));
        end

        // Ports 1 and 3 contending after a grant to port 3.
        clear_stats();
        start_pkt(3, 1);
        drain(50);
        check("rr13_setup", 256'(grant_port), 256'(3));
        clear_stats();
        auto_len[1] = 2;
        auto_len[3] = 2;
        start_pkt(1, 2);
        start_pkt(3, 2);
        repeat (30) tick();
        auto_len[1] = 0;
        auto_len[3] = 0;
        drain(100);
        check("rr13_count", 256'(got_grants.size() >= 6), 256'(1));
        for (int i = 0; i < 6 && i < got_grants.size(); i++) begin
            check($sformatf("rr13_g%0d", i), 256'(got_grants[i]), 256'((i % 2 == 0) ? 1 : 3));
        end

        // Reset pulse with a port-4 packet three beats in.
        clear_stats();
        start_pkt(4, 8);
        for (int n = 0; n < 20 && rem[4] > 5; n++) tick();
        check("rst_mid_progress", 256'(rem[4]), 256'(5));
        aresetn = 1'b0;
        #1;
        check("rst_mid_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        check("rst_mid_payload", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}, 256'(0));
        check("rst_mid_s_tready", 256'(s_axis_tready), 256'(0));
        check("rst_mid_busy", 256'(busy), 256'(0));
        clear_sources();
        exp_q.delete();
        prev_busy = 1'b0;
        prev_stall = 1'b0;
        @(posedge aclk);
        #1;
        check("rst_mid_grant", 256'(grant_port), 256'(NP - 1));
        aresetn = 1'b1;
        clear_stats();
        start_pkt(4, 2);
        start_pkt(0, 2);
        drain(100);
        check("rst_after_count", 256'(got_grants.size()), 256'(2));
        if (got_grants.size() == 2) begin
            check("rst_after_g0", 256'(got_grants[0]), 256'(0));
            check("rst_after_g1", 256'(got_grants[1]), 256'(4));
        end
        check("rst_after_beats", 256'(out_count), 256'(4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
